a2d_chan_model: RTL
===================

A2D_CHAN_MODEL -- requirements
Module: a2d_chan_model

Interface
REQ-001 Parameter NUM_CH, default 8, number of modelled A2D channels (1..8).
REQ-002 Parameter DATA_W, default 12, conversion result width (8..12).
REQ-003 Parameter BAD_RESP, default 16'h0001, response word for an invalid channel.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 SS_n  input  1  active-low slave select.
REQ-007 SCLK  input  1  serial clock, idle high.
REQ-008 MOSI  input  1  serial command in.
REQ-009 MISO  output  1  serial data out.
REQ-010 wr_en  input  1  load one channel's value/mode.
REQ-011 wr_ch  input  3  channel index for wr_en.
REQ-012 wr_val  input  DATA_W  value loaded.
REQ-013 wr_mode  input  2  00 static, 01 ramp-up, 10 ramp-down, 11 bounce.
REQ-014 wr_step  input  8  ramp step per completed read.
REQ-015 bad_ch  output  1  sticky flag: invalid channel commanded.
REQ-016 rd_cnt  output  16  count of completed data reads.

Function
REQ-017 SS_n, SCLK and MOSI SHALL be double-flop synchronised to clk before use.
REQ-018 Falling edge of SS_n SHALL clear the bit counter and load the 16-bit shift register with the current response word.
REQ-019 MOSI SHALL be sampled on each detected SCLK rise; the shift register SHALL shift on each detected SCLK fall; MISO SHALL equal shift register bit 15.
REQ-020 rdy SHALL pulse for one clk on the 16th detected SCLK rise of a frame; SS_n rising before that SHALL abort the frame with no rdy.
REQ-021 Protocol SM states FIRST, SECOND; reset to FIRST.
REQ-022 FIRST + rdy: latch channel = cmd[13:11], go SECOND.
REQ-023 SECOND + rdy: data read completes, rd_cnt +1 (wraps at 16'hFFFF->0), apply ramp to latched channel, go FIRST.
REQ-024 Response word SHALL be zero-extended value[channel] when channel < NUM_CH, else BAD_RESP.
REQ-025 Latching channel >= NUM_CH SHALL set bad_ch; cleared only by reset.
REQ-026 Ramp-up: value += step, wraps modulo 2^DATA_W.
REQ-027 Ramp-down: value -= step, saturates at 0.
REQ-028 Bounce: per-channel direction bit, reset up; move by step, clamp at 0 or 2^DATA_W-1 and reverse direction on clamp.
REQ-029 Static mode SHALL leave value unchanged on reads.
REQ-030 wr_en with wr_ch < NUM_CH SHALL write value, mode, step next clk and set bounce direction up; wr_ch >= NUM_CH ignored.
REQ-031 wr_en to the same channel in the same cycle as a ramp update: write wins.
REQ-032 Response word changes take effect only at the next SS_n fall; an in-flight frame is unaffected.

Reset
REQ-033 On rst_n low: state FIRST, channel 0, all values 0, modes static, steps 0, directions up, bad_ch 0, rd_cnt 0, shift register 0 (MISO 0), bit counter 0, synchronisers SS_n=1/SCLK=1/MOSI=0.
REQ-034 Reset mid-frame SHALL discard the frame; the next frame starts in FIRST.

Structure
REQ-035 Shared package a2d_pkg SHALL hold the mode enum, the SM state enum and the channel-field position constants.
REQ-036 SPI framing (REQ-017..020) SHALL be sub-module spi_slave16; channel storage, ramp and SM stay in the top.

Verification
REQ-039 Write ch0=12'h123 static; frames cmd ch0 then any -> 2nd frame MISO 16'h0123, rd_cnt=1.
REQ-040 ch4=12'hFF0 ramp-up step 16; three read pairs -> 0FF0, 0000, 0010.
REQ-041 ch5=12'h010 bounce step 8; reads -> 010, 018, ... through FF8, FFF, FF7 (reversal at max), each step verified.
REQ-042 NUM_CH=4, cmd ch6 -> response 16'h0001, bad_ch=1 held through later valid reads.
REQ-043 SS_n raised after 9 SCLK; next full frame -> state unchanged by aborted frame, correct data.
REQ-044 rst_n pulsed mid-second-frame -> all outputs at reset values, next pair returns 0 for ch0.

Source files
------------

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D channel model: channel modes,
// protocol state machine states and the command field carrying the channel.
package a2d_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  // Channel number position inside the 16-bit command word.
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;
  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/a2d_chan_model_if.sv
// Serial (SPI-style) link between the master and the A2D channel model.
interface a2d_chan_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_chan_model_spi_slave16.sv
// 16-bit serial slave: synchronises the link into clk, shifts the response
// word out on MISO and delivers the received command with a one-clk rdy.
module spi_slave16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ss_n_i,
  input  logic        sclk_i,
  input  logic        mosi_i,
  input  logic [15:0] resp_i,
  output logic        miso_o,
  output logic        rdy_o,
  output logic [15:0] cmd_o
);

  // [0] first flop, [1] second flop, [2] previous synchronised value
  logic [2:0]  ss_q;
  logic [2:0]  sclk_q;
  logic [1:0]  mosi_q;
  logic [15:0] shreg_q;
  logic [4:0]  cnt_q;
  logic        mosi_bit_q;
  logic        rdy_q;
  logic [15:0] cmd_q;

  logic ss_fall, frame_active, sclk_rise, sclk_fall, mosi_s;

  assign ss_fall      = ss_q[2] & ~ss_q[1];
  assign frame_active = ~ss_q[1];
  assign sclk_rise    = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall    = sclk_q[2] & ~sclk_q[1];
  assign mosi_s       = mosi_q[1];

  // Double-flop synchronisers plus one history stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n_i};
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  // Frame engine: load on SS_n fall, sample on SCLK rise, shift on SCLK fall.
  // The leading SCLK fall (before any rise) is skipped so bit 15 is presented
  // for the first rise; the 16th bit is taken straight from the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      mosi_bit_q <= 1'b0;
      rdy_q      <= 1'b0;
      cmd_q      <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (ss_fall) begin
        shreg_q    <= resp_i;
        cnt_q      <= '0;
        mosi_bit_q <= 1'b0;
      end else if (frame_active) begin
        if (sclk_rise && (int'(cnt_q) < FRAME_BITS)) begin
          mosi_bit_q <= mosi_s;
          cnt_q      <= cnt_q + 5'd1;
          if (int'(cnt_q) == FRAME_BITS - 1) begin
            rdy_q <= 1'b1;
            cmd_q <= {shreg_q[14:0], mosi_s};
          end
        end
        if (sclk_fall && (cnt_q != 5'd0)) begin
          shreg_q <= {shreg_q[14:0], mosi_bit_q};
        end
      end
    end
  end

  assign miso_o = shreg_q[15];
  assign rdy_o  = rdy_q;
  assign cmd_o  = cmd_q;

endmodule

// File: rtl/a2d_chan_model.sv
// A2D converter behavioural model: per-channel value/mode/step storage,
// ramping on completed reads and the two-frame command/data protocol.
module a2d_chan_model
  import a2d_pkg::*;
#(
  parameter int          NUM_CH   = 8,
  parameter int          DATA_W   = 12,
  parameter logic [15:0] BAD_RESP = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  a2d_chan_model_if.slave   spi,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [1:0]        wr_mode,
  input  logic [7:0]        wr_step,
  output logic              bad_ch,
  output logic [15:0]       rd_cnt
);

  localparam logic [20:0] MAX_X = 21'((1 << DATA_W) - 1);

  logic              rdy;
  logic [15:0]       cmd;
  logic [15:0]       resp_word;
  logic              miso;
  state_e            state_q;
  logic [2:0]        ch_q;
  logic              bad_ch_q;
  logic [15:0]       rd_cnt_q;
  logic [DATA_W-1:0] val_w [8];
  logic              unused_cmd_bits;

  assign unused_cmd_bits = ^{cmd[15:CH_MSB+1], cmd[CH_LSB-1:0]};

  spi_slave16 u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .ss_n_i (spi.SS_n),
    .sclk_i (spi.SCLK),
    .mosi_i (spi.MOSI),
    .resp_i (resp_word),
    .miso_o (miso),
    .rdy_o  (rdy),
    .cmd_o  (cmd)
  );

  assign spi.MISO = miso;

  // Response for the next frame: selected channel value, or the invalid marker.
  always_comb begin
    resp_word = BAD_RESP;
    if (int'(ch_q) < NUM_CH) resp_word = 16'(val_w[ch_q]);
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    if (gi < NUM_CH) begin : g_live
      logic [DATA_W-1:0] val_q, val_d;
      mode_e             mode_q, mode_d;
      logic [7:0]        step_q, step_d;
      logic              up_q, up_d;
      logic [20:0]       val_x, step_x, sum_x, diff_x;
      logic              ramp_hit, wr_hit;

      assign val_x    = 21'(val_q);
      assign step_x   = 21'(step_q);
      assign sum_x    = val_x + step_x;
      assign diff_x   = val_x - step_x;
      assign ramp_hit = rdy && (state_q == ST_SECOND) && (ch_q == 3'(gi));
      assign wr_hit   = wr_en && (wr_ch == 3'(gi));

      // Next channel state: ramp on a completed read, a host write overrides it.
      always_comb begin
        val_d  = val_q;
        mode_d = mode_q;
        step_d = step_q;
        up_d   = up_q;
        if (ramp_hit) begin
          case (mode_q)
            MODE_UP:   val_d = sum_x[DATA_W-1:0];
            MODE_DOWN: val_d = (val_x > step_x) ? diff_x[DATA_W-1:0] : '0;
            MODE_BOUNCE: begin
              if (up_q) begin
                if (sum_x >= MAX_X) begin
                  val_d = MAX_X[DATA_W-1:0];
                  up_d  = 1'b0;
                end else begin
                  val_d = sum_x[DATA_W-1:0];
                end
              end else begin
                if (val_x <= step_x) begin
                  val_d = '0;
                  up_d  = 1'b1;
                end else begin
                  val_d = diff_x[DATA_W-1:0];
                end
              end
            end
            default: val_d = val_q;
          endcase
        end
        if (wr_hit) begin
          val_d  = wr_val;
          mode_d = mode_e'(wr_mode);
          step_d = wr_step;
          up_d   = 1'b1;
        end
      end

      // Channel registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          val_q  <= '0;
          mode_q <= MODE_STATIC;
          step_q <= '0;
          up_q   <= 1'b1;
        end else begin
          val_q  <= val_d;
          mode_q <= mode_d;
          step_q <= step_d;
          up_q   <= up_d;
        end
      end

      assign val_w[gi] = val_q;
    end else begin : g_none
      assign val_w[gi] = '0;
    end
  end

  // Protocol SM: command frame latches the channel, data frame completes a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FIRST;
      ch_q     <= '0;
      bad_ch_q <= 1'b0;
      rd_cnt_q <= '0;
    end else if (rdy) begin
      case (state_q)
        ST_FIRST: begin
          ch_q    <= cmd[CH_MSB:CH_LSB];
          if (int'(cmd[CH_MSB:CH_LSB]) >= NUM_CH) bad_ch_q <= 1'b1;
          state_q <= ST_SECOND;
        end
        default: begin
          rd_cnt_q <= rd_cnt_q + 16'd1;
          state_q  <= ST_FIRST;
        end
      endcase
    end
  end

  assign bad_ch = bad_ch_q;
  assign rd_cnt = rd_cnt_q;

endmodule
